debug_view_sequencer: RTL

Front-panel debug controller between the single-cycle processor's debug ports and the four-digit multiplexed seven-segment display. It debounces the step pushbutton into single-cycle processor step pulses and drives the processor's debug register address. It sequences what the display shows: a manually chosen register or the current instruction, or an automatic scan over all 16 registers, alternating upper and lower halves. Outputs feed the Mux4Machine digit inputs (A–D) and its blank input.

---
 rtl/dbgview_pkg.sv | 19 +
 rtl/step_debouncer.sv | 38 +++
 rtl/debug_view_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/dbgview_pkg.sv
// Shared state encoding, display widths and half-word selector for the debug view sequencer.
package dbgview_pkg;
  localparam int NIBBLE_W   = 4;
  localparam int NUM_DIGITS = 4;
  localparam int REG_AW     = 4;
  localparam int WORD_W     = 32;
  localparam int HALF_W     = NIBBLE_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    MANUAL  = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2,
    GAP     = 2'd3
  } viewState_t;

  function automatic logic [HALF_W-1:0] pickHalf(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[WORD_W-1:HALF_W] : w[HALF_W-1:0];
  endfunction
endpackage

// File: rtl/step_debouncer.sv
// Step pushbutton conditioner: 2-FF synchronizer, stability counter, rising-edge one-shot.
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1, sync2, level, levelDly;
  logic [CW-1:0] stableCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level     <= 1'b0;
      levelDly  <= 1'b0;
      stableCnt <= '0;
      pulse     <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      levelDly <= level;
      pulse    <= level & ~levelDly;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 == level)
        stableCnt <= '0;
      else if (stableCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level     <= sync2;
        stableCnt <= '0;
      end else
        stableCnt <= stableCnt + CW'(1);
    end
  end
endmodule

// File: rtl/debug_view_sequencer.sv
// Front-panel debug view: manual/auto register scan sequencing into the 4-digit display, plus step button.
// Optional DBG_SCAN_GAP_EN inserts a blanked gap of DWELL_CYCLES/4 between scanned registers.
module debug_view_sequencer
  import dbgview_pkg::*;
#(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_btn,
  input  logic                  auto_scan,
  input  logic                  select,
  input  logic                  top_half,
  input  logic [REG_AW-1:0]     manual_reg,
  input  logic [WORD_W-1:0]     instr,
  input  logic [WORD_W-1:0]     reg_val,
  output logic [REG_AW-1:0]     reg_addr,
  output logic                  cpu_step,
  output logic [HALF_W-1:0]     digits,
  output logic                  half_hi,
  output logic [NUM_DIGITS-1:0] blank
);
  localparam int DWW = $clog2(DWELL_CYCLES);

  viewState_t     state, nextState;
  logic [DWW-1:0] dwell;
  logic           dwellDone, advance;

  assign dwellDone = (dwell == DWW'(DWELL_CYCLES - 1));

`ifdef DBG_SCAN_GAP_EN
  localparam int GAP_CYCLES = DWELL_CYCLES / 4;
  logic gapDone;
  assign gapDone = (dwell == DWW'(GAP_CYCLES - 1));
`endif

  step_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStep (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(step_btn),
    .pulse  (cpu_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= MANUAL;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MANUAL:  if (auto_scan) nextState = SHOW_HI;
      SHOW_HI: begin
        if (!auto_scan)     nextState = MANUAL;
        else if (dwellDone) nextState = SHOW_LO;
      end
      SHOW_LO: begin
        if (!auto_scan)     nextState = MANUAL;
        else if (dwellDone) begin
`ifdef DBG_SCAN_GAP_EN
          nextState = select ? SHOW_HI : GAP;
`else
          nextState = SHOW_HI;
`endif
        end
      end
`ifdef DBG_SCAN_GAP_EN
      GAP: begin
        if (!auto_scan)   nextState = MANUAL;
        else if (gapDone) nextState = SHOW_HI;
      end
`endif
      default: nextState = MANUAL;
    endcase
  end

  always_comb begin
    blank   = '0;
`ifdef DBG_SCAN_GAP_EN
    if (state == GAP) blank = '1;
`endif
    // Instruction view keeps the address; only register view walks the file.
    advance = (state == SHOW_LO) && auto_scan && dwellDone && !select;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell    <= '0;
      reg_addr <= '0;
      half_hi  <= 1'b1;
      digits   <= '0;
    end else begin
      digits <= pickHalf(select ? instr : reg_val, half_hi);
      // half_hi tracks the state being entered so digits follow one cycle behind it.
      half_hi <= (nextState == MANUAL) ? top_half : (nextState != SHOW_LO);
      if (state == nextState && state != MANUAL) dwell <= dwell + DWW'(1);
      else                                       dwell <= '0;
      if (state == MANUAL)  reg_addr <= auto_scan ? '0 : manual_reg;
      else if (advance)     reg_addr <= reg_addr + REG_AW'(1);
    end
  end
endmodule
